alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter CNT_W, default 8: width of the illegal-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline flush.
REQ-005 in_valid  input  1  upstream holds a valid instruction and operands.
REQ-006 in_ready  output  1  stage accepts input this cycle.
REQ-007 instr  input  32  RV32 instruction word.
REQ-008 rs1_val  input  32  register-file value for rs1.
REQ-009 rs2_val  input  32  register-file value for rs2.
REQ-010 out_valid  output  1  registered v1/v2/op/rd/illegal are valid for the ALU.
REQ-011 out_ready  input  1  downstream consumes the output this cycle.
REQ-012 v1  output  32  ALU operand 1, registered.
REQ-013 v2  output  32  ALU operand 2, registered.
REQ-014 op  output  13  one-hot ALU operation code, registered.
REQ-015 rd  output  5  destination register index, instr[11:7], registered.
REQ-016 illegal  output  1  registered flag: instruction is not a supported ALU op.
REQ-017 illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-018 op encoding SHALL be: add=1, sub=2, xor=4, or=8, and=16, sll=32, srl=64, sra=128, slt=256, sltu=512, mul=1024, div=2048, rem=4096.
REQ-019 opcode 0110011, funct7 0000000: funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and; v2=rs2_val.
REQ-020 opcode 0110011, funct7 0100000: funct3 000 sub, 101 sra; other funct3 illegal.
REQ-021 opcode 0110011, funct7 0000001: funct3 000 mul, 100 div, 110 rem; other funct3 illegal.
REQ-022 opcode 0010011: funct3 000 addi, 010 slti, 011 sltiu, 100 xori, 110 ori, 111 andi with v2 = sign-extended instr[31:20].
REQ-023 opcode 0010011 shifts: funct3 001 with instr[31:25]=0000000 -> sll; funct3 101 with 0000000 -> srl, 0100000 -> sra; v2 = zero-extended instr[24:20]; other instr[31:25] illegal.
REQ-024 v1 SHALL equal rs1_val for every legal op.
REQ-025 Any other opcode/funct combination SHALL produce op=0, illegal=1, v1=v2=0, rd still captured.
REQ-026 Single-entry pipeline register; latency exactly 1 cycle from acceptance to out_valid.
REQ-027 in_ready SHALL be combinational: !out_valid || out_ready (full throughput, one transfer per cycle).
REQ-028 Accept when in_valid && in_ready; load all output registers, set out_valid=1.
REQ-029 out_valid && out_ready && !(in_valid && in_ready): out_valid clears next cycle.
REQ-030 While out_valid && !out_ready, v1/v2/op/rd/illegal SHALL hold stable.
REQ-031 Simultaneous consume and accept: new entry replaces old, out_valid stays 1, no bubble.
REQ-032 flush=1: out_valid cleared next cycle, input that cycle discarded and not counted; illegal_cnt unchanged.
REQ-033 illegal_cnt increments by 1 per accepted illegal instruction; saturates at 2^CNT_W-1, never wraps.

Reset
REQ-034 rst_n=0 at a rising edge: out_valid=0, v1=0, v2=0, op=0, rd=0, illegal=0, illegal_cnt=0.
REQ-035 Reset SHALL dominate flush and in_valid; in-flight entry lost, in_ready=1 from the first cycle after reset deasserts.

Verification
REQ-036 instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=1, v1=5, v2=7, rd=3.
REQ-037 instr=0xFFF00093 (addi x1,x0,-1), rs1=0 -> op=1, v2=0xFFFFFFFF; instr=0x4030D093 (srai x1,x1,3) -> op=128, v2=3.
REQ-038 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> back-to-back transfers, no bubble, no loss.
REQ-039 CNT_W=2, five accepted instr=0xFFFFFFFF -> each op=0, illegal=1; illegal_cnt 1,2,3,3,3.
REQ-040 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, illegal_cnt unchanged; rst_n=0 mid-stall -> all outputs zero next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32 ALU instructions into one-hot ops and registers operands
module alu_issue_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      v1,
  output logic [31:0]      v2,
  output logic [12:0]      op,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [12:0] base, dop;
  logic [31:0] dv2;
  logic dill, acc, unused;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused = ^instr[19:15];
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready && !flush;
  // funct3 mapping shared by the funct7=0 register form and the immediate form
  always_comb begin
    base = '0;
    case (f3)
      3'd0: base = 13'd1;
      3'd1: base = 13'd32;
      3'd2: base = 13'd256;
      3'd3: base = 13'd512;
      3'd4: base = 13'd4;
      3'd5: base = 13'd64;
      3'd6: base = 13'd8;
      default: base = 13'd16;
    endcase
  end
  always_comb begin
    dop = '0;
    dv2 = '0;
    if (opc == 7'b0110011) begin
      dv2 = rs2_val;
      dop = f7 == 7'b0000000 ? base :
            f7 == 7'b0100000 ? (f3 == 3'd0 ? 13'd2 : f3 == 3'd5 ? 13'd128 : 13'd0) :
            f7 == 7'b0000001 ? (f3 == 3'd0 ? 13'd1024 : f3 == 3'd4 ? 13'd2048 :
                                f3 == 3'd6 ? 13'd4096 : 13'd0) : 13'd0;
    end else if (opc == 7'b0010011) begin
      dv2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      dop = f3 == 3'd1 ? (f7 == 7'b0000000 ? base : 13'd0) :
            f3 == 3'd5 ? (f7 == 7'b0000000 ? 13'd64 : f7 == 7'b0100000 ? 13'd128 : 13'd0) : base;
    end
    dill = dop == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      v1 <= '0;
      v2 <= '0;
      op <= '0;
      rd <= '0;
      illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      v1 <= dill ? 32'd0 : rs1_val;
      v2 <= dill ? 32'd0 : dv2;
      op <= dop;
      rd <= instr[11:7];
      illegal <= dill;
      if (dill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
